// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// data_mem_responder_pkg : bus widths, wait limits and FSM encoding
// Revision: 1.0
// ============================================================================
package data_mem_responder_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int BE_W     = 4;
  localparam int WAIT_MAX = 7;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// data_mem_responder_if : LSU data bus between a core and the data memory
// Revision: 1.0
// ============================================================================
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic              data_req_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic              data_we_i;
  logic [BE_W-1:0]   data_be_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic [DATA_W-1:0] data_rdata_o;
  logic              data_err_o;

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

endinterface
`default_nettype wire

// File: rtl/data_mem_responder_be_write_merge.sv
`default_nettype none
// ============================================================================
// be_write_merge : replaces the enabled byte lanes of a stored word
// Revision: 1.0
// ============================================================================
module be_write_merge
  import data_mem_responder_pkg::*;
(
  input  logic [DATA_W-1:0] old_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [DATA_W-1:0] merged_o
);

  for (genvar n = 0; n < BE_W; n++) begin : g_lane
    assign merged_o[8*n +: 8] = be_i[n] ? wdata_i[8*n +: 8] : old_i[8*n +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// data_mem_responder : single-outstanding data memory with optional grant stall
// Revision: 1.0
// ============================================================================
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int              DEPTH       = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int              WAIT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rvalid_q, rvalid_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               w_gnt;
  logic               w_acc;
  logic [ADDR_W-2:0]  w_woff;
  logic               w_err;
  logic [IDX_W-1:0]   w_idx;
  logic [DATA_W-1:0]  w_old;
  logic [DATA_W-1:0]  w_merged;
  logic               w_wr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_gnt   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.data_req_i) begin
          if (WAIT_CYCLES == 0) begin
            w_gnt = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.data_req_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        // move on in the cycle the counter decrements to zero
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_GRANT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GRANT: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        w_gnt   = bus.data_req_i;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.data_gnt_o = w_gnt & rst_n;
  assign w_acc          = bus.data_req_i & bus.data_gnt_o;

  // word-granular offset; the extra MSB is the borrow for addresses below the base
  assign w_woff = {1'b0, bus.data_addr_i[ADDR_W-1:2]} - {1'b0, BASE_ADDR[ADDR_W-1:2]};
  assign w_idx  = w_woff[IDX_W-1:0];
  assign w_err  = (bus.data_addr_i[1:0] != 2'b00)
                | w_woff[ADDR_W-2]
                | (w_woff[ADDR_W-3:0] >= (ADDR_W-2)'(DEPTH))
                | (bus.data_we_i & (bus.data_be_i == '0));
  assign w_old  = mem_q[w_idx];
  assign w_wr   = w_acc & bus.data_we_i & ~w_err;

  be_write_merge u_merge (
    .old_i    (w_old),
    .wdata_i  (bus.data_wdata_i),
    .be_i     (bus.data_be_i),
    .merged_o (w_merged)
  );

  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[w] <= '0;
      end else if (w_wr && (w_idx == IDX_W'(w))) begin
        mem_q[w] <= w_merged;
      end
    end
  end

  assign rvalid_d = w_acc;
  assign err_d    = w_acc & w_err;
  assign rdata_d  = (w_acc & ~bus.data_we_i & ~w_err) ? w_old : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.data_rvalid_o = rvalid_q;
  assign bus.data_err_o    = err_q;
  assign bus.data_rdata_o  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_data_mem_responder : random and directed checks against a word-array model
// Revision: 1.0
// ============================================================================
module tb_data_mem_responder;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE3 = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mdl [2][64];

  data_mem_responder_if if0 ();
  data_mem_responder_if if3 ();

  data_mem_responder #(.DEPTH(64), .BASE_ADDR(BASE0), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk), .rst_n (rst_n), .bus (if0.slave)
  );

  data_mem_responder #(.DEPTH(64), .BASE_ADDR(BASE3), .WAIT_CYCLES(3)) u_dut3 (
    .clk (clk), .rst_n (rst_n), .bus (if3.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference memory: a plain word array, byte-addressed from the given base.
  task automatic model_access(input int k, input logic we, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er);
    longint off;
    int     w;
    off = addr;
    off = off - ((k == 0) ? longint'(BASE0) : longint'(BASE3));
    rd  = 32'h0;
    er  = 1'b0;
    if ((addr % 4) != 0 || off < 0 || (off / 4) >= 64 || (we && be == 4'h0)) begin
      er = 1'b1;
    end else begin
      w = int'(off / 4);
      if (we) begin
        for (int n = 0; n < 4; n++)
          if (be[n]) mdl[k][w][8*n +: 8] = wd[8*n +: 8];
      end else begin
        rd = mdl[k][w];
      end
    end
  endtask

  function automatic logic [31:0] rnd_addr(input logic [31:0] base);
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0:       return base + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      1:       return base + 32'h100 + 4 * $urandom_range(0, 7);
      2:       return base - 4 * $urandom_range(1, 4);
      3:       return $urandom();
      default: return base + 4 * $urandom_range(0, 15);
    endcase
  endfunction

  // One cycle on the zero-wait port: drive, check gnt, then check the response.
  task automatic step0(input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] ed;
    logic        ee;
    ed = 32'h0;
    ee = 1'b0;
    @(negedge clk);
    if0.data_req_i   = req;
    if0.data_we_i    = we;
    if0.data_addr_i  = addr;
    if0.data_be_i    = be;
    if0.data_wdata_i = wd;
    #1;
    chk("gnt0", 32'(if0.data_gnt_o), 32'(req));
    if (req) model_access(0, we, addr, be, wd, ed, ee);
    @(posedge clk);
    #1;
    chk("rvalid0", 32'(if0.data_rvalid_o), 32'(req));
    chk("rdata0", if0.data_rdata_o, ed);
    chk("err0", 32'(if0.data_err_o), 32'(ee));
  endtask

  // A request on the three-stall port; drop_at < 0 holds req until granted.
  task automatic tx3(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input int drop_at);
    logic [31:0] ed;
    logic        ee;
    logic        held;
    ed   = 32'h0;
    ee   = 1'b0;
    held = (drop_at < 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if3.data_req_i   = held || (c < drop_at);
      if3.data_we_i    = we;
      if3.data_addr_i  = addr;
      if3.data_be_i    = be;
      if3.data_wdata_i = wd;
      #1;
      chk("gnt3", 32'(if3.data_gnt_o), 32'(held && c == 3));
      chk("rvalid3_early", 32'(if3.data_rvalid_o), 32'h0);
    end
    if (held) model_access(1, we, addr, be, wd, ed, ee);
    @(negedge clk);
    if3.data_req_i = 1'b0;
    #1;
    chk("rvalid3", 32'(if3.data_rvalid_o), 32'(held));
    chk("rdata3", if3.data_rdata_o, ed);
    chk("err3", 32'(if3.data_err_o), 32'(ee));
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 64; w++) mdl[k][w] = 32'h0;
    rst_n            = 1'b0;
    if0.data_req_i   = 1'b1;
    if0.data_we_i    = 1'b0;
    if0.data_addr_i  = 32'h0;
    if0.data_be_i    = 4'hF;
    if0.data_wdata_i = 32'h0;
    if3.data_req_i   = 1'b0;
    if3.data_we_i    = 1'b0;
    if3.data_addr_i  = 32'h0;
    if3.data_be_i    = 4'h0;
    if3.data_wdata_i = 32'h0;

    #12;
    chk("rst_gnt0", 32'(if0.data_gnt_o), 32'h0);
    chk("rst_rvalid0", 32'(if0.data_rvalid_o), 32'h0);
    chk("rst_rdata0", if0.data_rdata_o, 32'h0);
    chk("rst_err0", 32'(if0.data_err_o), 32'h0);
    chk("rst_rvalid3", 32'(if3.data_rvalid_o), 32'h0);
    @(negedge clk);
    if0.data_req_i = 1'b0;
    rst_n          = 1'b1;

    // directed traffic on the zero-wait port
    step0(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    step0(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    chk("wr_rd_deadbeef", if0.data_rdata_o, 32'hDEAD_BEEF);
    step0(1'b1, 1'b1, 32'h20, 4'hF, 32'h1122_3344);
    step0(1'b1, 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD);
    step0(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
    chk("partial_merge", if0.data_rdata_o, 32'h11BB_33DD);
    step0(1'b1, 1'b0, 32'h102, 4'hF, 32'h0);
    chk("misaligned_err", 32'(if0.data_err_o), 32'h1);
    step0(1'b1, 1'b1, 32'h100, 4'hF, 32'h5555_AAAA);
    chk("range_err", 32'(if0.data_err_o), 32'h1);
    step0(1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
    step0(1'b1, 1'b1, 32'h4, 4'h0, 32'hFFFF_FFFF);
    step0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    for (int i = 0; i < 300; i++)
      step0(($urandom_range(0, 5) != 0), $urandom_range(0, 1), rnd_addr(BASE0),
            4'($urandom_range(0, 15)), $urandom());
    step0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // stalled port: held request, withdrawal, then random traffic
    tx3(1'b1, BASE3 + 32'h8, 4'hF, 32'h0BAD_F00D, -1);
    tx3(1'b0, BASE3 + 32'h8, 4'hF, 32'h0, 1);
    tx3(1'b0, BASE3 + 32'h8, 4'hF, 32'h0, -1);
    chk("stall_read", if3.data_rdata_o, 32'h0BAD_F00D);
    tx3(1'b0, BASE3 - 32'h4, 4'hF, 32'h0, -1);
    chk("below_base_err", 32'(if3.data_err_o), 32'h1);
    for (int i = 0; i < 60; i++)
      tx3($urandom_range(0, 1), rnd_addr(BASE3), 4'($urandom_range(0, 15)), $urandom(),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : -1);

    // reset inside the grant cycle of a write
    @(negedge clk);
    if0.data_req_i   = 1'b1;
    if0.data_we_i    = 1'b1;
    if0.data_addr_i  = 32'h40;
    if0.data_be_i    = 4'hF;
    if0.data_wdata_i = 32'hCAFE_F00D;
    #1;
    chk("gnt_before_rst", 32'(if0.data_gnt_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("gnt_in_rst", 32'(if0.data_gnt_o), 32'h0);
    @(posedge clk);
    #1;
    chk("rvalid_in_rst", 32'(if0.data_rvalid_o), 32'h0);
    @(negedge clk);
    if0.data_req_i = 1'b0;
    rst_n          = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 64; w++) mdl[k][w] = 32'h0;
    @(posedge clk);
    #1;
    chk("rvalid_after_rst", 32'(if0.data_rvalid_o), 32'h0);
    for (int w = 0; w < 64; w++)
      step0(1'b1, 1'b0, 32'(4 * w), 4'hF, 32'h0);
    step0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int w = 0; w < 16; w++)
      tx3(1'b0, BASE3 + 32'(4 * w), 4'hF, 32'h0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
